// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: parameter legality and chunk sizing.
package adder_pkg;

  function automatic bit cfg_legal(int width, int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic int chunk_w(int width, int stages);
    return (stages >= 1) ? width / stages : width;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chains.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple chain; also exposes the carry into its MSB for overflow.
module rca_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .c_i(c[i]),
      .s_o(sum_o[i]),
      .c_o(c[i+1])
    );
  end

  assign cout_o = c[N];
  assign cmsb_o = c[N-1];
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder whose carry chain is cut into STAGES registered chunks,
// with a global-stall valid/ready handshake on both sides.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CH = chunk_w(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } sum_result_t;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  logic [STAGES-1:0]            v_q, v_d, c_q, c_d, c_in;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d, s_in;
  logic [STAGES-1:0][CH-1:0]    cs;
  logic [WIDTH-1:0]             a_q [STAGES];
  logic [WIDTH-1:0]             b_q [STAGES];
  logic [WIDTH-1:0]             a_in [STAGES];
  logic [WIDTH-1:0]             b_in [STAGES];
  logic                         cm [STAGES];
  logic                         ovf_q, advance;
  sum_result_t                  res;

  assign advance  = !v_q[L] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign v_d[0]  = in_valid;
      assign a_in[0] = a;
      assign b_in[0] = b;
      assign c_in[0] = cin;
      assign s_in[0] = '0;
    end else begin : g_body
      assign v_d[k]  = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    rca_chunk #(.N(CH)) u_rca (
      .a_i   (a_in[k][k*CH +: CH]),
      .b_i   (b_in[k][k*CH +: CH]),
      .cin_i (c_in[k]),
      .sum_o (cs[k]),
      .cout_o(c_d[k]),
      .cmsb_o(cm[k])
    );

    // Chunks above k are still zero here, so OR-ing places this chunk in situ.
    assign s_d[k] = s_in[k] | (WIDTH'(cs[k]) << (k * CH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      s_q   <= s_d;
      ovf_q <= c_d[L] ^ cm[L];
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
      end
    end
  end

  assign res       = '{sum: s_q[L], cout: c_q[L], ovf: ovf_q};
  assign sum       = res.sum;
  assign cout      = res.cout;
  assign ovf       = res.ovf;
  assign out_valid = v_q[L];
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: queue model for an 8/2 and a 32/4 instance,
// plus 8-bit instances with 1, 4 and 8 stages for latency checks.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: STAGES=2 (modelled), 1: STAGES=1, 2: STAGES=4, 3: STAGES=8
  logic [7:0] a8 = '0, b8 = '0;
  logic cin8 = 1'b0, iv8 = 1'b0, or8 = 1'b1;
  logic [3:0] vv, vr, vc, vo;
  logic [3:0][7:0] vs;

  logic [31:0] a32 = '0, b32 = '0, s32;
  logic cin32 = 1'b0, iv32 = 1'b0, or32 = 1'b1, ir32, ov32, c32, o32;

  int n_tests = 0, n_fail = 0;
  logic [33:0] q8[$], q32[$];
  logic [7:0]  seen[$];
  logic        fz8 = 1'b0, fz32 = 1'b0;
  logic [10:0] held8;
  logic [34:0] held32;
  int exp_lat[4] = '{2, 1, 4, 8};

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_main (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(vr[0]), .a(a8), .b(b8), .cin(cin8),
    .out_valid(vv[0]), .out_ready(or8), .sum(vs[0]), .cout(vc[0]), .ovf(vo[0]));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(vr[1]), .a(a8), .b(b8), .cin(cin8),
    .out_valid(vv[1]), .out_ready(or8), .sum(vs[1]), .cout(vc[1]), .ovf(vo[1]));
  pipelined_adder #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(vr[2]), .a(a8), .b(b8), .cin(cin8),
    .out_valid(vv[2]), .out_ready(or8), .sum(vs[2]), .cout(vc[2]), .ovf(vo[2]));
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(vr[3]), .a(a8), .b(b8), .cin(cin8),
    .out_valid(vv[3]), .out_ready(or8), .sum(vs[3]), .cout(vc[3]), .ovf(vo[3]));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(c32), .ovf(o32));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h @%0t", nm, got, want, $time);
    end
  endtask

  // Result as {ovf, cout, sum} from integer arithmetic on w-bit operands.
  function automatic logic [33:0] ref_add(int w, logic [31:0] x, logic [31:0] y, logic c);
    longint xu, yu, t, half, xs, ys, r;
    logic [31:0] s;
    logic co, ov;
    xu = longint'({32'd0, x});
    yu = longint'({32'd0, y});
    t = xu + yu + longint'(c);
    half = longint'(1) << (w - 1);
    s = 32'(t % (2 * half));
    co = (t / (2 * half)) != 0;
    xs = (xu >= half) ? xu - 2 * half : xu;
    ys = (yu >= half) ? yu - 2 * half : yu;
    r = xs + ys + longint'(c);
    ov = (r >= half) || (r < -half);
    return {ov, co, s};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q32.delete();
      fz8  = 1'b0;
      fz32 = 1'b0;
    end else begin
      if (fz8)  chk("hold8", 64'({vv[0], vc[0], vo[0], vs[0]}), 64'(held8));
      if (fz32) chk("hold32", 64'({ov32, c32, o32, s32}), 64'(held32));
      if (vv[0] && !or8) chk("stall_inrdy8", 64'(vr[0]), 64'(0));
      if (ov32 && !or32) chk("stall_inrdy32", 64'(ir32), 64'(0));
      fz8    = vv[0] && !or8;
      held8  = {vv[0], vc[0], vo[0], vs[0]};
      fz32   = ov32 && !or32;
      held32 = {ov32, c32, o32, s32};
      if (vv[0] && or8) begin
        if (q8.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out8_unexpected got sum %h want no beat @%0t", vs[0], $time);
        end else begin
          chk("out8", 64'({vo[0], vc[0], 24'd0, vs[0]}), 64'(q8.pop_front()));
          seen.push_back(vs[0]);
        end
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out32_unexpected got sum %h want no beat @%0t", s32, $time);
        end else chk("out32", 64'({o32, c32, s32}), 64'(q32.pop_front()));
      end
      if (iv8 && vr[0]) q8.push_back(ref_add(8, 32'(a8), 32'(b8), cin8));
      if (iv32 && ir32) q32.push_back(ref_add(32, a32, b32, cin32));
    end
  end

  // One beat into all 8-bit instances; literal result and per-instance latency.
  task automatic send_one(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input logic eo);
    int lat[4];
    logic [9:0] got[4];
    @(posedge clk); #1;
    a8 = ta; b8 = tb_; cin8 = tc; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
    for (int d = 0; d < 4; d++) begin lat[d] = 0; got[d] = '0; end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (vv[d] && lat[d] == 0) begin
          lat[d] = n;
          got[d] = {vo[d], vc[d], vs[d]};
        end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("lat_s%0d", exp_lat[d]), 64'(lat[d]), 64'(exp_lat[d]));
      chk($sformatf("res_s%0d_%h_%h", exp_lat[d], ta, tb_), 64'(got[d]), 64'({eo, ec, es}));
    end
  endtask

  task automatic push8(input logic [7:0] x, input logic [7:0] y);
    bit acc;
    int k;
    a8 = x; b8 = y; cin8 = 1'b0; iv8 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      acc = vr[0];
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 50);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL push8_timeout got not accepted want accepted @%0t", $time);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_valid", 64'(vv[d]), 64'(0));
      chk("rst_res", 64'({vo[d], vc[d], vs[d]}), 64'(0));
      chk("rst_inrdy", 64'(vr[d]), 64'(1));
    end
    chk("rst_w32", 64'({ov32, c32, o32, s32}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // carry across chunk boundary, overflow cases, full carry ripple
    send_one(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send_one(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send_one(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    send_one(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);
    send_one(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // asynchronous reset with two beats in flight
    @(posedge clk); #1;
    a8 = 8'hC0; b8 = 8'hC0; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("pre_rst_valid", 64'(vv[0]), 64'(1));
    chk("pre_rst_res", 64'({vo[0], vc[0], vs[0]}), 64'({1'b0, 1'b1, 8'h80}));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(vv[0]), 64'(0));
    chk("rst_async_res", 64'({vo[0], vc[0], vs[0]}), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("post_rst_inrdy", 64'(vr[0]), 64'(1));
    repeat (8) begin
      @(negedge clk);
      chk("no_stale", 64'(vv[0]), 64'(0));
    end

    // back-to-back stream with a 3-cycle output stall
    seen.delete();
    @(posedge clk); #1;
    or8 = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) push8(8'(i), 8'(i));
        iv8 = 1'b0;
      end
      begin
        int k;
        k = 0;
        while (!vv[0] && k < 50) begin @(posedge clk); #1; k++; end
        chk("s5_first_result", 64'(vv[0]), 64'(1));
        or8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        or8 = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("s5_count", 64'(seen.size()), 64'(5));
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk($sformatf("s5_order%0d", i), 64'(seen[i]), 64'(2 * (i + 1)));

    // random traffic on the 32-bit / 4-stage instance
    begin
      int acc, cyc;
      acc = 0; cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
        @(posedge clk); #1;
        iv32  = ($urandom_range(0, 3) != 0);
        or32  = ($urandom_range(0, 3) != 0);
        a32   = pick();
        b32   = pick();
        cin32 = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (iv32 && ir32) acc++;
        cyc++;
      end
      chk("rand_beats", 64'(acc), 64'(10000));
      @(posedge clk); #1;
      iv32 = 1'b0; or32 = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("drain8", 64'(q8.size()), 64'(0));
      chk("drain32", 64'(q32.size()), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder: the next generation of the team's fixed-width full-adder datapath. Adds two `WIDTH`-bit operands plus carry-in and returns sum, carry-out and signed overflow. The carry chain is split into `STAGES` registered chunks, so timing closes at any width. A valid/ready handshake on both sides lets it drop into streaming datapaths with backpressure.

## Interface
- `WIDTH`, default 8: operand and sum width in bits.
- `STAGES`, default 2: pipeline depth (number of carry chunks).
  - Legal range: 1 ≤ `STAGES` ≤ `WIDTH`, with `WIDTH % STAGES == 0`.
  - Elaboration fails otherwise.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operand beat offered.
- `in_ready` output 1: block accepts a beat this cycle.
- `a` input `WIDTH`: operand A, unsigned or two's complement.
- `b` input `WIDTH`: operand B.
- `cin` input 1: carry-in.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: downstream accepts the result.
- `sum` output `WIDTH`: (a + b + cin) mod 2^`WIDTH`.
- `cout` output 1: carry out of the MSB.
- `ovf` output 1: signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- CHUNK = `WIDTH / STAGES`.
- Stage k (0..`STAGES`-1) adds bits [k·CHUNK +: CHUNK] of the operands with the carry registered by stage k-1. Stage 0 uses `cin`.
- Each stage register holds:
  - valid bit v[k];
  - the completed low sum bits;
  - the carry;
  - the not-yet-added high operand bits, delay-aligned so they reach their stage with the matching carry.
- The last stage also registers `cout` and `ovf`. Outputs `sum`, `cout`, `ovf` and `out_valid` are driven directly from last-stage registers, with no combinational path from `a`, `b` or `cin`.
- Pipeline control uses a global stall:
  - advance = !out_valid || out_ready
  - in_ready = advance
  - All stage registers load only when advance is high. When advance is low, every register, including outputs, holds.
- A beat is accepted when in_valid && in_ready at a rising edge. v[0] loads in_valid on every advance.
- Bubbles are not squeezed out. An empty stage behind a stalled output still stalls.
- Beats are never dropped, duplicated or reordered.
- `STAGES` = 1 degenerates to a single registered adder with latency 1.

## Timing
- Reset, asynchronous on `rst` high, effective immediately, including mid-transaction:
  - all v[k] = 0;
  - all data registers = 0;
  - `sum` = 0, `cout` = 0, `ovf` = 0, `out_valid` = 0;
  - in-flight beats are discarded;
  - `in_ready` = 1 (combinational, since out_valid = 0).
- Latency: a beat accepted at edge E appears on the outputs immediately after edge E + `STAGES` − 1.
- Throughput: one beat per cycle while `out_ready` stays high.
- With out_valid high and out_ready low, the outputs are frozen and `in_ready` is low in the same cycle.
- When out_ready rises while the pipeline is full, the result completes and a new beat is accepted at the same edge.
- Operands need only be stable in the accepting cycle. They are don't-care otherwise.

## Structure
- Package `adder_pkg`:
  - compile-time check function for the WIDTH/STAGES legality rule;
  - a CHUNK-computing constant function;
  - a `sum_result_t` struct {sum, cout, ovf} parameterised via `WIDTH`, as a typedef in the consuming module.
- Sub-module `rca_chunk` (parameter `N`): a combinational N-bit ripple chain built from the existing `full_adder` cell. It returns an N-bit sum, the carry out, and the carry into its MSB (used for `ovf`).
- `pipelined_adder` instantiates `STAGES` `rca_chunk`s in a generate loop, plus the stage registers and the stall logic.

## Test plan
Default parameters unless stated.
1. Assert `rst` mid-stream with two beats in flight → `out_valid`, `sum`, `cout`, `ovf` drop to 0 without waiting for a clock edge. After release, `in_ready` = 1 and no stale beat ever emerges.
2. a=8'hFF, b=8'h01, cin=0, out_ready=1 → after 2 edges: sum=8'h00, cout=1, ovf=0. The carry crosses the chunk boundary.
3. a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
4. a=8'h0F, b=8'hF0, cin=1 → sum=8'h00, cout=1. Repeat with `STAGES`=1, 4 and 8 → same result, with latency 1, 4 and 8 respectively.
5. Stream 5 beats (1+1, 2+2, …, 5+5) back-to-back, hold out_ready=0 for 3 cycles starting when the first result appears → `in_ready`=0 and outputs frozen during the stall. Results 2, 4, 6, 8, 10 emerge in order, none lost or duplicated.
6. Random a/b/cin, random in_valid/out_ready, ≥10k beats, `WIDTH`=32, `STAGES`=4 → scoreboard matches {cout, sum} = a + b + cin and the `ovf` reference for every beat.
